// File: rtl/load_store_unit_if.sv
// Data-bus interface between the load/store unit (master) and the memory
// slave. Avalon-MM style single-transfer bus.
//   address_o     word-aligned byte address
//   read_o        read strobe
//   write_o       write strobe (never together with read_o)
//   byteenable_o  little-endian byte lanes
//   writedata_o   store data, unused lanes zero
//   readdata_i    read data, valid when read_o=1 and waitrequest_i=0
//   waitrequest_i slave stall
interface load_store_unit_if;
  logic [31:0] address_o;
  logic        read_o;
  logic        write_o;
  logic [3:0]  byteenable_o;
  logic [31:0] writedata_o;
  logic [31:0] readdata_i;
  logic        waitrequest_i;

  modport master (
    output address_o, read_o, write_o, byteenable_o, writedata_o,
    input  readdata_i, waitrequest_i
  );

  modport slave (
    input  address_o, read_o, write_o, byteenable_o, writedata_o,
    output readdata_i, waitrequest_i
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage following the ALU. Runs one bus transfer per
// load/store (LB/LBU/LH/LHU/LW/SB/SH/SW), steers store bytes onto lanes,
// checks alignment and returns the extended load result.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start_i               request valid (sampled in IDLE only)
//   opcode_i              6-bit opcode, only load/store codes act
//   effective_address_i   byte address from ALU
//   rt_i                  store data (low bits)
//   busy_o                high whenever not IDLE
//   done_o                one-cycle pulse on successful completion
//   load_data_o           extended load result, held until the next load
//   addr_error_o          one-cycle pulse on misaligned request
//   bus_error_o           one-cycle pulse on waitrequest timeout
//   bus                   data-bus master modport
// MAX_WAIT: consecutive waitrequest cycles tolerated before abort, 0 = forever.
module load_store_unit #(
  parameter int MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [5:0]  opcode_i,
  input  logic [31:0] effective_address_i,
  input  logic [31:0] rt_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        addr_error_o,
  output logic        bus_error_o,
  load_store_unit_if.master bus
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP, S_ERR} state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_op;
  logic [1:0]  r_ofs;
  logic        r_is_load;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic [31:0] r_wait_cnt;
  logic [31:0] r_load_data;
  logic        r_bus_err;

  logic        w_is_mem;
  logic        w_is_load;
  logic [1:0]  w_size;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic        w_accept;
  logic        w_timeout;

  // Pick the addressed byte/half out of the bus word and extend it.
  function automatic logic [31:0] load_extend(input logic [5:0]  op,
                                              input logic [1:0]  ofs,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{ofs, 3'b000} +: 8];
    h = rd[{ofs[1], 4'b0000} +: 16];
    case (op)
      OP_LB:   load_extend = {{24{b[7]}}, b};
      OP_LBU:  load_extend = {24'd0, b};
      OP_LH:   load_extend = {{16{h[15]}}, h};
      OP_LHU:  load_extend = {16'd0, h};
      default: load_extend = rd;
    endcase
  endfunction

  // Request decode: size, direction, alignment, lane steering.
  always_comb begin
    w_is_mem  = 1'b1;
    w_is_load = 1'b0;
    w_size    = SZ_WORD;
    case (opcode_i)
      OP_LB, OP_LBU: begin w_is_load = 1'b1; w_size = SZ_BYTE; end
      OP_LH, OP_LHU: begin w_is_load = 1'b1; w_size = SZ_HALF; end
      OP_LW:         begin w_is_load = 1'b1; w_size = SZ_WORD; end
      OP_SB:         w_size = SZ_BYTE;
      OP_SH:         w_size = SZ_HALF;
      OP_SW:         w_size = SZ_WORD;
      default:       w_is_mem = 1'b0;
    endcase

    w_misaligned = ((w_size == SZ_HALF) && effective_address_i[0]) ||
                   ((w_size == SZ_WORD) && (effective_address_i[1:0] != 2'b00));

    case (w_size)
      SZ_BYTE: begin
        w_be = 4'b0001 << effective_address_i[1:0];
        w_wd = {4{rt_i[7:0]}};
      end
      SZ_HALF: begin
        w_be = effective_address_i[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{rt_i[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = rt_i;
      end
    endcase
    // Replicated data masked down to the enabled lanes only.
    w_wd = w_wd & {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  end

  assign w_accept  = (r_state == S_IDLE) && start_i && w_is_mem;
  // Abort on the cycle whose stall would make the count reach MAX_WAIT.
  assign w_timeout = (MAX_WAIT > 0) && bus.waitrequest_i &&
                     ((r_wait_cnt + 32'd1) == 32'(MAX_WAIT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_misaligned ? S_ERR : S_BUS;
      S_BUS: begin
        if (!bus.waitrequest_i) w_next = S_RESP;
        else if (w_timeout)     w_next = S_IDLE;
      end
      S_RESP:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op        <= '0;
      r_ofs       <= '0;
      r_is_load   <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wd        <= '0;
      r_wait_cnt  <= '0;
      r_load_data <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= (r_state == S_BUS) && w_timeout;
      if (w_accept) begin
        r_op       <= opcode_i;
        r_ofs      <= effective_address_i[1:0];
        r_is_load  <= w_is_load;
        r_addr     <= {effective_address_i[31:2], 2'b00};
        r_be       <= w_be;
        r_wd       <= w_wd;
        r_wait_cnt <= '0;
      end
      if (r_state == S_BUS) begin
        if (bus.waitrequest_i) begin
          r_wait_cnt <= r_wait_cnt + 32'd1;
        end else if (r_is_load) begin
          r_load_data <= load_extend(r_op, r_ofs, bus.readdata_i);
        end
      end
    end
  end

  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_RESP);
  assign addr_error_o = (r_state == S_ERR);
  assign bus_error_o  = r_bus_err;
  assign load_data_o  = r_load_data;

  assign bus.address_o    = r_addr;
  assign bus.byteenable_o = r_be;
  assign bus.writedata_o  = r_wd;
  assign bus.read_o       = (r_state == S_BUS) && r_is_load;
  assign bus.write_o      = (r_state == S_BUS) && !r_is_load;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with MAX_WAIT=4 and a hand-driven slave.
module tb_load_store_unit;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [5:0]  opcode_i;
  logic [31:0] ea;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic [31:0] ld;
  logic        aerr;
  logic        berr;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit_if bus_if ();

  load_store_unit #(.MAX_WAIT(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start_i             (start_i),
    .opcode_i            (opcode_i),
    .effective_address_i (ea),
    .rt_i                (rt),
    .busy_o              (busy),
    .done_o              (done),
    .load_data_o         (ld),
    .addr_error_o        (aerr),
    .bus_error_o         (berr),
    .bus                 (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete transfer with 'waits' stall cycles and hand-computed results.
  task automatic xfer(input string tag, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] rd, input int waits,
                      input logic is_ld, input logic [31:0] exp_addr,
                      input logic [31:0] exp_be, input logic [31:0] exp_wd,
                      input logic [31:0] exp_ld);
    opcode_i = op;
    ea       = a;
    rt       = d;
    bus_if.readdata_i    = rd;
    bus_if.waitrequest_i = (waits > 0);
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
    for (int i = 0; i < waits; i++) begin
      check_eq({tag, " strobe in wait"}, 32'(is_ld ? bus_if.read_o : bus_if.write_o), 32'h1);
      check_eq({tag, " done in wait"}, 32'(done), 32'h0);
      tick();
    end
    bus_if.waitrequest_i = 1'b0;
    check_eq({tag, " strobe"}, 32'(is_ld ? bus_if.read_o : bus_if.write_o), 32'h1);
    check_eq({tag, " other strobe"}, 32'(is_ld ? bus_if.write_o : bus_if.read_o), 32'h0);
    check_eq({tag, " address"}, bus_if.address_o, exp_addr);
    check_eq({tag, " byteenable"}, 32'(bus_if.byteenable_o), exp_be);
    if (!is_ld) check_eq({tag, " writedata"}, bus_if.writedata_o, exp_wd);
    tick();
    check_eq({tag, " done"}, 32'(done), 32'h1);
    check_eq({tag, " load_data"}, ld, exp_ld);
    check_eq({tag, " strobe after"}, 32'(bus_if.read_o | bus_if.write_o), 32'h0);
    tick();
    check_eq({tag, " done end"}, 32'(done), 32'h0);
    check_eq({tag, " busy end"}, 32'(busy), 32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start_i  = 1'b0;
    opcode_i = 6'h00;
    ea       = 32'h0;
    rt       = 32'h0;
    bus_if.readdata_i    = 32'h0;
    bus_if.waitrequest_i = 1'b0;
    tick();
    tick();
    check_eq("reset busy", 32'(busy), 32'h0);
    check_eq("reset done", 32'(done), 32'h0);
    check_eq("reset load_data", ld, 32'h0);
    check_eq("reset strobes", 32'(bus_if.read_o | bus_if.write_o), 32'h0);
    check_eq("reset errors", 32'(aerr | berr), 32'h0);
    check_eq("reset address", bus_if.address_o, 32'h0);
    check_eq("reset byteenable", 32'(bus_if.byteenable_o), 32'h0);
    rst_n = 1'b1;
    tick();

    xfer("LW 100",  OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1, 32'h100, 32'hF, 32'h0, 32'hDEADBEEF);
    xfer("LB 103",  OP_LB,  32'h103, 32'h0, 32'h80FF0000, 0, 1'b1, 32'h100, 32'h8, 32'h0, 32'hFFFFFF80);
    xfer("LBU 103", OP_LBU, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b1, 32'h100, 32'h8, 32'h0, 32'h00000080);
    xfer("SH 202",  OP_SH,  32'h202, 32'h1234ABCD, 32'h0, 3, 1'b0, 32'h200, 32'hC, 32'hABCD0000, 32'h00000080);
    xfer("LH 102",  OP_LH,  32'h102, 32'h0, 32'h80010000, 1, 1'b1, 32'h100, 32'hC, 32'h0, 32'hFFFF8001);
    xfer("LHU 100", OP_LHU, 32'h100, 32'h0, 32'h1234F00D, 0, 1'b1, 32'h100, 32'h3, 32'h0, 32'h0000F00D);
    xfer("SB 101",  OP_SB,  32'h101, 32'hAABBCC77, 32'h0, 0, 1'b0, 32'h100, 32'h2, 32'h00007700, 32'h0000F00D);
    xfer("SW 300",  OP_SW,  32'h300, 32'hCAFEF00D, 32'h0, 2, 1'b0, 32'h300, 32'hF, 32'hCAFEF00D, 32'h0000F00D);

    // Misaligned word load: error pulse, no bus cycle.
    opcode_i = OP_LW; ea = 32'h101; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_eq("LW 101 addr_error", 32'(aerr), 32'h1);
    check_eq("LW 101 read", 32'(bus_if.read_o), 32'h0);
    check_eq("LW 101 busy c1", 32'(busy), 32'h1);
    tick();
    check_eq("LW 101 busy c2", 32'(busy), 32'h0);
    check_eq("LW 101 addr_error c2", 32'(aerr), 32'h0);
    check_eq("LW 101 no read c2", 32'(bus_if.read_o), 32'h0);

    // Misaligned half store.
    opcode_i = OP_SH; ea = 32'h203; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_eq("SH 203 addr_error", 32'(aerr), 32'h1);
    check_eq("SH 203 write", 32'(bus_if.write_o), 32'h0);
    tick();

    // Non-memory opcode is ignored.
    opcode_i = 6'h00; ea = 32'h100; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_eq("non-mem busy", 32'(busy), 32'h0);
    check_eq("non-mem read", 32'(bus_if.read_o), 32'h0);

    // start_i held high: ignored during RESP, accepted in the following IDLE cycle.
    opcode_i = OP_LW; ea = 32'h108; bus_if.readdata_i = 32'h01234567; start_i = 1'b1;
    tick();
    check_eq("b2b read c1", 32'(bus_if.read_o), 32'h1);
    tick();
    check_eq("b2b done c2", 32'(done), 32'h1);
    check_eq("b2b load_data c2", ld, 32'h01234567);
    tick();
    check_eq("b2b busy c3", 32'(busy), 32'h0);
    check_eq("b2b read c3", 32'(bus_if.read_o), 32'h0);
    tick();
    start_i = 1'b0;
    check_eq("b2b read c4", 32'(bus_if.read_o), 32'h1);
    tick();
    check_eq("b2b done c5", 32'(done), 32'h1);
    tick();

    // Timeout: waitrequest stuck, MAX_WAIT=4.
    opcode_i = OP_LW; ea = 32'h400; bus_if.waitrequest_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_eq("timeout read c1", 32'(bus_if.read_o), 32'h1);
    tick();
    check_eq("timeout read c2", 32'(bus_if.read_o), 32'h1);
    opcode_i = OP_LB; ea = 32'h501; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_eq("timeout read c3", 32'(bus_if.read_o), 32'h1);
    check_eq("timeout address c3", bus_if.address_o, 32'h400);
    check_eq("timeout byteenable c3", 32'(bus_if.byteenable_o), 32'hF);
    tick();
    check_eq("timeout read c4", 32'(bus_if.read_o), 32'h1);
    check_eq("timeout bus_error c4", 32'(berr), 32'h0);
    tick();
    check_eq("timeout read c5", 32'(bus_if.read_o), 32'h0);
    check_eq("timeout bus_error c5", 32'(berr), 32'h1);
    check_eq("timeout done c5", 32'(done), 32'h0);
    check_eq("timeout busy c5", 32'(busy), 32'h0);
    tick();
    check_eq("timeout bus_error c6", 32'(berr), 32'h0);
    check_eq("timeout done c6", 32'(done), 32'h0);
    check_eq("timeout read c6", 32'(bus_if.read_o), 32'h0);
    check_eq("timeout load_data", ld, 32'h01234567);
    bus_if.waitrequest_i = 1'b0;

    // Reset in the middle of a stalled store.
    opcode_i = OP_SW; ea = 32'h500; rt = 32'h11223344; bus_if.waitrequest_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_eq("rst-mid write c1", 32'(bus_if.write_o), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus_if.waitrequest_i = 1'b0;
    check_eq("rst-mid write", 32'(bus_if.write_o), 32'h0);
    check_eq("rst-mid done", 32'(done), 32'h0);
    check_eq("rst-mid busy", 32'(busy), 32'h0);
    check_eq("rst-mid load_data", ld, 32'h0);
    tick();
    check_eq("rst-mid done after", 32'(done), 32'h0);

    xfer("LW 104", OP_LW, 32'h104, 32'h0, 32'h5A5A1234, 0, 1'b1, 32'h104, 32'hF, 32'h0, 32'h5A5A1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
